crc8_frame_rx: RTL
==================

Name: crc8_frame_rx

Overview:
- Receive side of the team's CRC-8-protected byte framing. Frame on the wire: SYNC, LEN, LEN payload bytes, CRC.
- Hunts for SYNC, streams payload bytes out, and recomputes CRC-8 over LEN and the payload.
- Issues a one-cycle ok/err verdict per frame and keeps saturating statistics counters.
- Sits between the byte-stream deframer (UART/SPI side) and the DDS register/command decoder.

Parameters:
- MAX_LEN, 64: largest accepted LEN value (1..255).
- SYNC_BYTE, 8'hA5: frame start marker.
- TIMEOUT_CYC, 1024: inter-byte idle cycles before abort (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data valid this cycle (always accepted; no backpressure).
- in_data  in  8  received byte.
- out_valid  out  1  payload byte valid.
- out_data  out  8  payload byte.
- out_last  out  1  marks the final payload byte of a frame.
- frame_ok  out  1  one-cycle pulse: CRC matched.
- frame_err  out  1  one-cycle pulse: frame aborted or CRC mismatch.
- err_code  out  2  01 = CRC, 10 = LEN, 11 = TIMEOUT; held until the next verdict.
- busy  out  1  high in any state other than HUNT.
- ok_cnt  out  16  good frames, saturates at 16'hFFFF.
- err_cnt  out  16  bad frames, saturates at 16'hFFFF.

Behaviour:
- Reset: all outputs 0; state HUNT; crc_reg 8'h00; counters 0.
- CRC definition:
  - Polynomial x^8+x^2+x+1 (0x07), init 0x00, MSB-first, no reflection, no final XOR.
  - Check value: "123456789" gives 8'hF4.
  - Computed over the LEN byte and the payload bytes only; SYNC is excluded.
- States:
  - HUNT: bytes other than SYNC_BYTE are discarded silently. SYNC_BYTE -> LEN, crc_reg cleared.
  - LEN: LEN = 0 -> CRC state. LEN > MAX_LEN -> frame_err with err_code 10, then HUNT. Otherwise -> PAYLOAD with remaining-count = LEN. LEN is folded into the CRC in all non-error cases.
  - PAYLOAD: each accepted byte updates the CRC, decrements the count, and is echoed on out_data/out_valid. The byte at count = 1 also asserts out_last and moves to CRC.
  - CRC: the received byte is compared with crc_reg. Match -> frame_ok. Mismatch -> frame_err with err_code 01. Either way -> HUNT.
- Latency:
  - out_valid/out_data/out_last are registered, one cycle after the accepting in_valid edge.
  - frame_ok/frame_err pulse one cycle after the CRC byte is accepted.
- The payload is forwarded before the verdict. Downstream buffers the payload and discards it on frame_err.
- Cycles with in_valid = 0 hold state; gaps are legal anywhere.
- SYNC_BYTE values appearing inside LEN, PAYLOAD or CRC are data; there is no resynchronisation mid-frame.
- Counters: ok_cnt increments on frame_ok, err_cnt on frame_err; both hold at 16'hFFFF.
- Reset asserted mid-frame: immediate return to HUNT, no verdict pulse, counters cleared.
- frame_ok and frame_err are never high in the same cycle.

Optional Feature:
- Macro: CRC8_FRAME_RX_TIMEOUT_EN.
- Defined:
  - An idle counter counts consecutive in_valid = 0 cycles while busy, and clears on any in_valid.
  - On reaching TIMEOUT_CYC: frame_err with err_code 11, err_cnt increments, state -> HUNT.
  - Counter width is $clog2(TIMEOUT_CYC+1).
- Undefined: no counter is built; the block waits indefinitely; err_code 11 is never produced.

Decomposition:
- Shared package crc8_pkg holds:
  - CRC8_POLY (8'h07) and CRC8_INIT (8'h00).
  - Function crc8_next(crc, data) implementing the byte-wise update equations.
  - State enum typedef (HUNT, LEN, PAYLOAD, CRC).
  - err_code localparams.
- The existing transmit-side CRC generator uses the same package function.
- Single module, no sub-module; the CRC update is the package function, not an instance.

Test Plan:
- A5 03 01 02 03 72, back-to-back -> out_data 01, 02, 03 with out_last on 03; frame_ok one cycle after 72; ok_cnt = 1.
- Same frame with CRC byte 73 -> payload still forwarded; frame_err, err_code 01, err_cnt = 1.
- Garbage 00 FF 5A, then A5 00 00 (LEN = 0, CRC of 00 is 00) -> no out_valid; a single frame_ok.
- A5 41 (LEN 65 > MAX_LEN 64) -> frame_err, err_code 10; the next A5 03 01 02 03 72 still passes.
- Frame with 3-cycle in_valid gaps between bytes -> identical outputs to the back-to-back case. With CRC8_FRAME_RX_TIMEOUT_EN and TIMEOUT_CYC = 8: A5 03 01 then 8 idle cycles -> frame_err, err_code 11.
- rst pulse after A5 03 01 -> busy 0, no pulses, counters 0; the following valid frame gives frame_ok.

Source files
------------

// File: rtl/crc8_pkg.sv
// Shared CRC-8 (poly 0x07, init 0x00, MSB-first) definitions for the frame RX/TX pair.
package crc8_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam logic [7:0] CRC8_INIT = 8'h00;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_CRC     = 2'b01;
  localparam logic [1:0] ERR_LEN     = 2'b10;
  localparam logic [1:0] ERR_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    HUNT,
    LEN,
    PAYLOAD,
    CRC
  } rx_state_e;

  // One whole byte per call; the loop unrolls into the parallel XOR network.
  function automatic logic [7:0] crc8_next(input logic [7:0] crc, input logic [7:0] data);
    logic [7:0] c;
    c = crc ^ data;
    for (int unsigned i = 0; i < 8; i++) begin
      c = {c[6:0], 1'b0} ^ (c[7] ? CRC8_POLY : 8'h00);
    end
    return c;
  endfunction

endpackage

// File: rtl/crc8_frame_rx.sv
// CRC-8 framed byte receiver: SYNC, LEN, payload, CRC; forwards payload, pulses ok/err verdict.
// Optional inter-byte idle abort enabled by defining CRC8_FRAME_RX_TIMEOUT_EN.
module crc8_frame_rx
  import crc8_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 64,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
  parameter int unsigned TIMEOUT_CYC = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        out_valid,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code,
  output logic        busy,
  output logic [15:0] ok_cnt,
  output logic [15:0] err_cnt
);

  rx_state_e   state_q, state_d;
  logic [7:0]  crc_q, crc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        out_valid_q, out_valid_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_last_q, out_last_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [1:0]  err_code_q, err_code_d;
  logic [15:0] ok_cnt_q, ok_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        timeout;

`ifdef CRC8_FRAME_RX_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYC + 1);
  logic [IDLE_W-1:0] idle_q, idle_d;

  always_comb begin
    idle_d  = '0;
    timeout = 1'b0;
    if (state_q != HUNT && !in_valid) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYC - 1)) timeout = 1'b1;
      else                                    idle_d  = idle_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    crc_d       = crc_q;
    cnt_d       = cnt_q;
    out_valid_d = 1'b0;
    out_data_d  = out_data_q;
    out_last_d  = 1'b0;
    ok_d        = 1'b0;
    err_d       = 1'b0;
    err_code_d  = err_code_q;

    if (timeout) begin
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
      state_d    = HUNT;
    end else if (in_valid) begin
      unique case (state_q)
        HUNT: begin
          if (in_data == SYNC_BYTE) begin
            state_d = LEN;
            crc_d   = CRC8_INIT;
          end
        end
        LEN: begin
          if (32'(in_data) > MAX_LEN) begin
            err_d      = 1'b1;
            err_code_d = ERR_LEN;
            state_d    = HUNT;
          end else begin
            crc_d   = crc8_next(crc_q, in_data);
            cnt_d   = in_data;
            state_d = (in_data == 8'h00) ? CRC : PAYLOAD;
          end
        end
        PAYLOAD: begin
          crc_d       = crc8_next(crc_q, in_data);
          cnt_d       = cnt_q - 8'd1;
          out_valid_d = 1'b1;
          out_data_d  = in_data;
          out_last_d  = (cnt_q == 8'd1);
          if (cnt_q == 8'd1) state_d = CRC;
        end
        CRC: begin
          if (in_data == crc_q) begin
            ok_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_CRC;
          end
          state_d = HUNT;
        end
        default: state_d = HUNT;
      endcase
    end

    ok_cnt_d  = (ok_d  && ok_cnt_q  != '1) ? ok_cnt_q  + 16'd1 : ok_cnt_q;
    err_cnt_d = (err_d && err_cnt_q != '1) ? err_cnt_q + 16'd1 : err_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      crc_q       <= CRC8_INIT;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      ok_q        <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= ERR_NONE;
      ok_cnt_q    <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      crc_q       <= crc_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      ok_q        <= ok_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      ok_cnt_q    <= ok_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign frame_ok  = ok_q;
  assign frame_err = err_q;
  assign err_code  = err_code_q;
  assign busy      = (state_q != HUNT);
  assign ok_cnt    = ok_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule
